// File: rtl/flex_pts_uart_tx.sv
// Parallel-to-serial UART transmitter: accepts a word on a valid/ready handshake and
// shifts out start bit, NUM_BITS data bits and STOP_BITS stop bits, CLKS_PER_BIT clocks each.
module flex_pts_uart_tx #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1,
  parameter bit SHIFT_MSB    = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(NUM_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [NUM_BITS-1:0] shreg, shreg_n;
  logic                serial_n, done_n;

  logic                bit_end;
  logic                out_bit;
  logic [NUM_BITS-1:0] shifted;

  assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Vacated positions fill with 1 so the register drains to line-idle after the last data bit.
  assign out_bit = SHIFT_MSB ? shreg[NUM_BITS-1] : shreg[0];
  assign shifted = SHIFT_MSB ? {shreg[NUM_BITS-2:0], 1'b1} : {1'b1, shreg[NUM_BITS-1:1]};

  // NOTE: the shift register is a handful of flops, not a memory, so it is reset to all 1s
  // like every other state element; nothing here relies on power-up contents.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!n_rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '1;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      clk_cnt    <= clk_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      serial_out <= serial_n;
      tx_done    <= done_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_n   = state;
    clk_cnt_n = bit_end ? '0 : clk_cnt + CNT_W'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    serial_n  = serial_out;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (tx_valid) begin
          state_n   = START;
          shreg_n   = tx_data;
          serial_n  = 1'b0;
          bit_cnt_n = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n  = DATA;
          serial_n = out_bit;
          shreg_n  = shifted;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(NUM_BITS - 1)) begin
            state_n   = STOP;
            serial_n  = 1'b1;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            serial_n  = out_bit;
            shreg_n   = shifted;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            state_n   = IDLE;
            done_n    = 1'b1;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_flex_pts_uart_tx.sv
// Directed bench for flex_pts_uart_tx: three instances cover LSB-first/1 stop,
// MSB-first, and a short-bit two-stop-bit configuration.
module tb_flex_pts_uart_tx;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [7:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic ready_a, so_a, busy_a, done_a;
  logic ready_b, so_b, busy_b, done_b;
  logic ready_c, so_c, busy_c, done_c;

  flex_pts_uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(10), .STOP_BITS(1), .SHIFT_MSB(1'b0)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .serial_out(so_a), .tx_busy(busy_a), .tx_done(done_a));

  flex_pts_uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(10), .STOP_BITS(1), .SHIFT_MSB(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .serial_out(so_b), .tx_busy(busy_b), .tx_done(done_b));

  flex_pts_uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .SHIFT_MSB(1'b0)) dut_c (
    .clk(clk), .n_rst(n_rst), .tx_data(data_c), .tx_valid(valid_c),
    .tx_ready(ready_c), .serial_out(so_c), .tx_busy(busy_c), .tx_done(done_c));

  int   sel;
  logic so_m, ready_m, busy_m, done_m;
  always_comb begin
    so_m = so_a; ready_m = ready_a; busy_m = busy_a; done_m = done_a;
    if (sel == 1) begin
      so_m = so_b; ready_m = ready_b; busy_m = busy_b; done_m = done_b;
    end else if (sel == 2) begin
      so_m = so_c; ready_m = ready_c; busy_m = busy_c; done_m = done_c;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] rx_bits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; checks every bit period, then the done cycle at accept+F.
  task automatic capture_frame(input string tag, input int cpb, input int nbit,
                               input logic [0:15] exp_bits);
    logic [15:0] vec, mask;
    int early;
    early = 0;
    mask  = 16'((32'd1 << cpb) - 1);
    check({tag, " busy_after_accept"}, busy_m, 1);
    check({tag, " ready_after_accept"}, ready_m, 0);
    for (int b = 0; b < nbit; b++) begin
      vec = '0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        vec[c] = so_m;
        if (done_m) early++;
        if (c == cpb / 2) rx_bits[b] = so_m;
      end
      check($sformatf("%s bit%0d", tag, b), vec, exp_bits[b] ? mask : 16'h0);
    end
    check({tag, " early_done"}, early, 0);
    @(negedge clk);
    check({tag, " done_at_F"}, done_m, 1);
    check({tag, " line_at_F"}, so_m, 1);
    check({tag, " ready_at_F"}, ready_m, 1);
    check({tag, " busy_at_F"}, busy_m, 0);
  endtask

  task automatic accept_a(input logic [7:0] d);
    data_a = d; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    data_a  = ~d;
  endtask

  initial begin
    int bad, dones;
    logic [7:0] word;
    sel = 0;
    n_rst = 1'b0;
    valid_a = 0; valid_b = 0; valid_c = 0;
    data_a = 0; data_b = 0; data_c = 0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // 1: idle after reset
    @(negedge clk);
    check("rst serial_out", so_a, 1);
    check("rst tx_ready", ready_a, 1);
    check("rst tx_busy", busy_a, 0);
    check("rst tx_done", done_a, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({so_a, ready_a, busy_a, done_a} !== 4'b1100) bad++;
      if ({so_b, ready_b, busy_b, done_b} !== 4'b1100) bad++;
      if ({so_c, ready_c, busy_c, done_c} !== 4'b1100) bad++;
    end
    check("idle 50clk", bad, 0);

    // 2: 0xA5 LSB first
    @(posedge clk); #1;
    accept_a(8'hA5);
    capture_frame("a5", 10, 10, 16'b0101001011_000000);
    @(negedge clk);
    check("a5 done_one_cycle", done_a, 0);

    // 3: 0x81 MSB first, receiver model rebuilds the word from mid-bit samples
    sel = 1;
    data_b = 8'h81; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0; data_b = 8'h00;
    capture_frame("msb81", 10, 10, 16'b0100000011_000000);
    word = '0;
    for (int i = 0; i < 8; i++) word[7-i] = rx_bits[1+i];
    check("msb81 rx_word", word, 8'h81);

    // 4: back-to-back with tx_valid held high; mid-frame data changes ignored
    sel = 0;
    @(negedge clk);
    data_a = 8'h00; valid_a = 1'b1;
    @(posedge clk); #1;
    data_a = 8'hFF;
    capture_frame("b2b00", 10, 10, 16'b0000000001_000000);
    @(posedge clk); #1;
    data_a = 8'h55;
    capture_frame("b2bFF", 10, 10, 16'b0111111111_000000);
    valid_a = 1'b0;

    // 5: reset 45 clocks into a 0x3C frame
    @(posedge clk); #1;
    accept_a(8'h3C);
    repeat (45) @(negedge clk);
    check("abort busy_before", busy_a, 1);
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("abort serial_out", so_a, 1);
    check("abort tx_ready", ready_a, 1);
    check("abort tx_busy", busy_a, 0);
    check("abort tx_done", done_a, 0);
    n_rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done_a || !ready_a || !so_a) dones++;
    end
    check("abort no_done_idle", dones, 0);
    @(posedge clk); #1;
    accept_a(8'h3C);
    capture_frame("post3C", 10, 10, 16'b0001111001_000000);

    // 6: two stop bits, 4 clocks per bit, F = 44
    sel = 2;
    @(negedge clk);
    data_c = 8'h0F; valid_c = 1'b1;
    @(posedge clk); #1;
    valid_c = 1'b0; data_c = 8'h00;
    capture_frame("stop2", 4, 11, 16'b0111100001_100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
